id_serializer: RTL and testbench

ID_SERIALIZER -- requirements
Module: id_serializer

---
 rtl/id_serializer.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_id_serializer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_serializer.sv
// -----------------------------------------------------------------------------
// id_serializer
//
// Sits between fetch and execute. Instructions are queued in a small FIFO and
// passed to EXE one per handshake. When the decoder marks the head entry as
// serializing (syscall / LL / SC), the block replaces it with BUBBLES nop
// slots. It raises a one-cycle SYS request to the simulator on the last of
// those slots, and retires the entry when that slot is accepted. Fetch is
// asked to hold its PC (WANT_FREEZE) while the sequence is running. The
// request drops one slot early so fetch can start refilling.
//
// Parameters
//   BUBBLES  bubble slots per serializing instruction (2..7)
//   DEPTH    input queue entries (power of two, 2..8)
//
// Ports
//   CLK           clock, all state on rising edge
//   RESET         asynchronous, active-low reset
//   FLUSH         synchronous discard of queued and in-progress work
//   In_Valid      fetch presents an instruction
//   In_Ready      queue not full (combinational)
//   Instr_IN      instruction word
//   Instr_PC_IN   instruction PC
//   Serialize_IN  instruction is serializing (syscall/LL/SC)
//   IsLLSC_IN     serializing instruction is LL or SC
//   Out_Valid     slot presented to EXE
//   Out_Ready     EXE accepts the slot
//   Instr_OUT     instruction word, or bubble word during a sequence
//   Instr_PC_OUT  PC of the head entry (0 when the queue is empty)
//   Out_Bubble    slot is a nop with no side effects
//   SYS           registered one-cycle request to the simulator
//   WANT_FREEZE   fetch shall hold its PC
//
// Optional feature
//   LLSC_SILENT_EN  when defined, SYS is suppressed for LL/SC entries. Bubbles
//                   and freeze behaviour do not change. When undefined,
//                   IsLLSC_IN is ignored.
// -----------------------------------------------------------------------------
module id_serializer #(
  parameter int BUBBLES = 4,
  parameter int DEPTH   = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [31:0] Instr_IN,
  input  logic [31:0] Instr_PC_IN,
  input  logic        Serialize_IN,
  input  logic        IsLLSC_IN,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Instr_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic        Out_Bubble,
  output logic        SYS,
  output logic        WANT_FREEZE
);

  localparam int          AW           = $clog2(DEPTH);
  localparam logic [2:0]  CNT_LOAD     = 3'(BUBBLES);
  localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SER  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Queue storage and pointers. The pointers carry one extra wrap bit, so
  // equal pointers mean empty and pointers differing only in the wrap bit
  // mean full.
  // ---------------------------------------------------------------------------
  logic [31:0] instr_mem_q [DEPTH];
  logic [31:0] pc_mem_q    [DEPTH];
  logic        ser_mem_q   [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic        empty_s;
  logic        full_s;
  logic        push_s;
  logic        pop_s;

  logic [31:0] head_instr_s;
  logic [31:0] head_pc_s;
  logic        head_ser_s;
  logic        sys_allowed_s;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sys_q, sys_d;

  logic        out_valid_s;
  logic        out_bubble_s;
  logic [31:0] instr_out_s;
  logic        freeze_s;

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign head_instr_s = instr_mem_q[rd_ptr_q[AW-1:0]];
  assign head_pc_s    = pc_mem_q[rd_ptr_q[AW-1:0]];
  assign head_ser_s   = ser_mem_q[rd_ptr_q[AW-1:0]];

`ifdef LLSC_SILENT_EN
  logic llsc_mem_q [DEPTH];
  logic head_llsc_s;

  assign head_llsc_s   = llsc_mem_q[rd_ptr_q[AW-1:0]];
  assign sys_allowed_s = ~head_llsc_s;

  // LL/SC flag storage, written alongside the rest of the entry
  always_ff @(posedge CLK) begin
    if (push_s) begin
      llsc_mem_q[wr_ptr_q[AW-1:0]] <= IsLLSC_IN;
    end
  end
`else
  logic unused_llsc_s;

  assign unused_llsc_s = IsLLSC_IN;
  assign sys_allowed_s = 1'b1;
`endif

  // In_Ready reflects fullness only. A push that lands while the queue is full
  // is still taken when the head pops in the same cycle.
  assign In_Ready = ~full_s;

  // Slot decode from the current state and the queue head
  always_comb begin
    pop_s        = 1'b0;
    out_valid_s  = 1'b0;
    out_bubble_s = 1'b0;
    instr_out_s  = 32'h0000_0000;
    freeze_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (empty_s) begin
          pop_s = 1'b0;
        end else if (head_ser_s) begin
          // Serializing head is held back for one cycle while SER is entered
          freeze_s = 1'b1;
        end else begin
          out_valid_s = 1'b1;
          instr_out_s = head_instr_s;
          pop_s       = Out_Ready;
        end
      end
      ST_SER: begin
        out_valid_s  = 1'b1;
        out_bubble_s = 1'b1;
        if (head_instr_s == SYSCALL_WORD) begin
          instr_out_s = head_instr_s;
        end else begin
          instr_out_s = 32'h0000_0000;
        end
        if (cnt_q > 3'd1) begin
          freeze_s = 1'b1;
        end else begin
          freeze_s = 1'b0;
        end
        if ((cnt_q == 3'd1) && Out_Ready) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase
  end

  // Queue push and pointer next state. FLUSH wins over any push or pop.
  always_comb begin
    push_s   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (FLUSH) begin
      wr_ptr_d = {(AW+1){1'b0}};
      rd_ptr_d = {(AW+1){1'b0}};
    end else begin
      push_s = In_Valid && (~full_s || pop_s);
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Queue pointer registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry payload storage; contents are only observed through a valid pointer
  always_ff @(posedge CLK) begin
    if (push_s) begin
      instr_mem_q[wr_ptr_q[AW-1:0]] <= Instr_IN;
      pc_mem_q[wr_ptr_q[AW-1:0]]    <= Instr_PC_IN;
      ser_mem_q[wr_ptr_q[AW-1:0]]   <= Serialize_IN;
    end
  end

  // Serialization sequencer next state: bubble counter and SYS request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sys_d   = sys_q;
    if (FLUSH) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      sys_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty_s && head_ser_s) begin
            state_d = ST_SER;
            cnt_d   = CNT_LOAD;
            sys_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SER: begin
          if (!Out_Ready) begin
            // Stalled EXE freezes the whole sequence, SYS included
            state_d = ST_SER;
          end else if (cnt_q == 3'd1) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            sys_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - 3'd1;
            // SYS rises together with the load of cnt==1
            sys_d = (cnt_q == 3'd2) && sys_allowed_s;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
          sys_d   = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      sys_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sys_q   <= sys_d;
    end
  end

  assign Out_Valid    = out_valid_s;
  assign Out_Bubble   = out_bubble_s;
  assign Instr_OUT    = instr_out_s;
  assign Instr_PC_OUT = empty_s ? 32'h0000_0000 : head_pc_s;
  assign SYS          = sys_q;
  assign WANT_FREEZE  = freeze_s;

endmodule

// File: tb/tb_id_serializer.sv
module tb_id_serializer;

  localparam int BUBBLES = 4;
  localparam int DEPTH   = 2;
`ifdef LLSC_SILENT_EN
  localparam logic SILENT = 1'b1;
`else
  localparam logic SILENT = 1'b0;
`endif
  localparam logic [31:0] SYSC = 32'h0000_000C;
  localparam logic [31:0] ADD1 = 32'h0022_1820;
  localparam logic [31:0] ADD2 = 32'h0043_2020;
  localparam logic [31:0] ADD3 = 32'h0064_2820;
  localparam logic [31:0] LLW  = 32'hC000_0000;
  localparam logic [31:0] SCW  = 32'hE000_0000;

  logic        CLK = 1'b0;
  logic        RESET, FLUSH, In_Valid, In_Ready;
  logic [31:0] Instr_IN, Instr_PC_IN;
  logic        Serialize_IN, IsLLSC_IN;
  logic        Out_Valid, Out_Ready;
  logic [31:0] Instr_OUT, Instr_PC_OUT;
  logic        Out_Bubble, SYS, WANT_FREEZE;

  id_serializer #(.BUBBLES(BUBBLES), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Instr_IN(Instr_IN), .Instr_PC_IN(Instr_PC_IN),
    .Serialize_IN(Serialize_IN), .IsLLSC_IN(IsLLSC_IN),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Instr_OUT(Instr_OUT), .Instr_PC_OUT(Instr_PC_OUT),
    .Out_Bubble(Out_Bubble), .SYS(SYS), .WANT_FREEZE(WANT_FREEZE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ser;
    logic        llsc;
    logic [31:0] exp_word;
    logic        exp_sys;
  } vec_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic        bub;
    logic        sys;
  } slot_t;

  vec_t  vecs [8];
  slot_t sb_q [$];
  int    passed = 0;
  int    total  = 0;
  logic  sb_en  = 1'b0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic monitor();
    slot_t e;
    if (sb_en && Out_Valid === 1'b1 && Out_Ready) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL sb_extra: got slot %0h expected no slot", Instr_OUT);
      end else begin
        e = sb_q.pop_front();
        chk("sb_slot", {Instr_OUT, Instr_PC_OUT, Out_Bubble, SYS}, e);
      end
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_cyc(input string nm, input logic ov, input logic bub,
                            input logic [31:0] word, input logic [31:0] pc,
                            input logic sys, input logic wf);
    @(negedge CLK);
    if (ov) chk(nm, {Out_Valid, Out_Bubble, SYS, WANT_FREEZE, Instr_OUT, Instr_PC_OUT},
                {ov, bub, sys, wf, word, pc});
    else    chk(nm, {Out_Valid, SYS, WANT_FREEZE}, {ov, sys, wf});
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic ser, input logic llsc);
    In_Valid = 1'b1; Instr_IN = instr; Instr_PC_IN = pc;
    Serialize_IN = ser; IsLLSC_IN = llsc;
  endtask

  task automatic idle_in();
    In_Valid = 1'b0; Serialize_IN = 1'b0; IsLLSC_IN = 1'b0;
  endtask

  initial begin
    int n, t1, t2, seen, waits;

    vecs[0] = '{ADD1, 32'h100, 1'b0, 1'b0, ADD1,  1'b0};
    vecs[1] = '{SYSC, 32'h104, 1'b1, 1'b0, SYSC,  1'b1};
    vecs[2] = '{ADD2, 32'h108, 1'b0, 1'b0, ADD2,  1'b0};
    vecs[3] = '{LLW,  32'h10C, 1'b1, 1'b1, 32'h0, ~SILENT};
    vecs[4] = '{SCW,  32'h110, 1'b1, 1'b1, 32'h0, ~SILENT};
    vecs[5] = '{SYSC, 32'h114, 1'b1, 1'b0, SYSC,  1'b1};
    vecs[6] = '{SYSC, 32'h118, 1'b1, 1'b0, SYSC,  1'b1};
    vecs[7] = '{ADD3, 32'h11C, 1'b0, 1'b0, ADD3,  1'b0};

    RESET = 1'b0; FLUSH = 1'b0; Out_Ready = 1'b0;
    Instr_IN = 32'h0; Instr_PC_IN = 32'h0; idle_in();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    chk("rst_out_valid",  Out_Valid,    1'b0);
    chk("rst_out_bubble", Out_Bubble,   1'b0);
    chk("rst_instr_out",  Instr_OUT,    32'h0);
    chk("rst_pc_out",     Instr_PC_OUT, 32'h0);
    chk("rst_freeze",     WANT_FREEZE,  1'b0);
    chk("rst_in_ready",   In_Ready,     1'b1);
    chk("rst_sys",        SYS,          1'b0);
    @(posedge CLK); #1;

    // Single syscall, EXE always ready
    Out_Ready = 1'b1; drive(SYSC, 32'h400, 1'b1, 1'b0);
    expect_cyc("A_push", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle_in();
    expect_cyc("A_idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    expect_cyc("A_b1",   1'b1, 1'b1, SYSC, 32'h400, 1'b0, 1'b1);
    expect_cyc("A_b2",   1'b1, 1'b1, SYSC, 32'h400, 1'b0, 1'b1);
    expect_cyc("A_b3",   1'b1, 1'b1, SYSC, 32'h400, 1'b0, 1'b1);
    expect_cyc("A_b4",   1'b1, 1'b1, SYSC, 32'h400, 1'b1, 1'b0);
    expect_cyc("A_done", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Fill the queue with EXE stalled, then drain with a push while full
    Out_Ready = 1'b0; drive(ADD1, 32'h200, 1'b0, 1'b0);
    expect_cyc("B_push1", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(ADD2, 32'h204, 1'b0, 1'b0);
    expect_cyc("B_push2", 1'b1, 1'b0, ADD1, 32'h200, 1'b0, 1'b0);
    chk("B_full_ready", In_Ready, 1'b0);
    Out_Ready = 1'b1; drive(ADD3, 32'h208, 1'b0, 1'b0);
    expect_cyc("B_out1", 1'b1, 1'b0, ADD1, 32'h200, 1'b0, 1'b0);
    idle_in();
    chk("B_swap_ready", In_Ready, 1'b0);
    expect_cyc("B_out2", 1'b1, 1'b0, ADD2, 32'h204, 1'b0, 1'b0);
    chk("B_ready_back", In_Ready, 1'b1);
    expect_cyc("B_out3", 1'b1, 1'b0, ADD3, 32'h208, 1'b0, 1'b0);
    expect_cyc("B_empty", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // LL: bubble word 0, SYS depends on build option
    drive(LLW, 32'h300, 1'b1, 1'b1);
    expect_cyc("F_push", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle_in();
    expect_cyc("F_idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    expect_cyc("F_b1", 1'b1, 1'b1, 32'h0, 32'h300, 1'b0, 1'b1);
    expect_cyc("F_b2", 1'b1, 1'b1, 32'h0, 32'h300, 1'b0, 1'b1);
    expect_cyc("F_b3", 1'b1, 1'b1, 32'h0, 32'h300, 1'b0, 1'b1);
    expect_cyc("F_b4", 1'b1, 1'b1, 32'h0, 32'h300, ~SILENT, 1'b0);
    expect_cyc("F_done", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Back-to-back syscalls: two SYS pulses five cycles apart
    n = 0; t1 = -1; t2 = -1;
    drive(SYSC, 32'h500, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (SYS) begin
        n++;
        if (n == 1) t1 = i; else t2 = i;
      end
      @(posedge CLK); #1;
      if (i == 0) drive(SYSC, 32'h504, 1'b1, 1'b0);
      else idle_in();
    end
    chk("C_sys_count", n, 2);
    chk("C_first_sys", t1, 5);
    chk("C_sys_gap", t2 - t1, 5);

    // FLUSH at cnt==2 drops the sequence and a simultaneous push
    drive(SYSC, 32'h600, 1'b1, 1'b0);
    expect_cyc("D_push", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle_in();
    expect_cyc("D_idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    expect_cyc("D_b1", 1'b1, 1'b1, SYSC, 32'h600, 1'b0, 1'b1);
    expect_cyc("D_b2", 1'b1, 1'b1, SYSC, 32'h600, 1'b0, 1'b1);
    FLUSH = 1'b1; drive(ADD1, 32'h604, 1'b0, 1'b0);
    expect_cyc("D_flush", 1'b1, 1'b1, SYSC, 32'h600, 1'b0, 1'b1);
    FLUSH = 1'b0; idle_in();
    chk("D_in_ready", In_Ready, 1'b1);
    expect_cyc("D_after", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_cyc("D_dropped", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // EXE stall for 3 cycles at cnt==3 delays SYS, still one cycle wide
    drive(SYSC, 32'h700, 1'b1, 1'b0);
    expect_cyc("E_push", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle_in();
    expect_cyc("E_idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    expect_cyc("E_b1", 1'b1, 1'b1, SYSC, 32'h700, 1'b0, 1'b1);
    Out_Ready = 1'b0;
    for (int i = 0; i < 3; i++)
      expect_cyc("E_stall", 1'b1, 1'b1, SYSC, 32'h700, 1'b0, 1'b1);
    Out_Ready = 1'b1;
    expect_cyc("E_b2", 1'b1, 1'b1, SYSC, 32'h700, 1'b0, 1'b1);
    expect_cyc("E_b3", 1'b1, 1'b1, SYSC, 32'h700, 1'b0, 1'b1);
    expect_cyc("E_b4", 1'b1, 1'b1, SYSC, 32'h700, 1'b1, 1'b0);
    expect_cyc("E_done", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset in the middle of a sequence abandons it
    drive(SYSC, 32'h800, 1'b1, 1'b0);
    expect_cyc("G_push", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle_in();
    expect_cyc("G_idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    expect_cyc("G_b1", 1'b1, 1'b1, SYSC, 32'h800, 1'b0, 1'b1);
    #2 RESET = 1'b0;
    #1;
    chk("G_async", {Out_Valid, SYS, WANT_FREEZE, In_Ready}, 4'b0001);
    @(posedge CLK); #1 RESET = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (SYS || Out_Valid) seen++;
      @(posedge CLK); #1;
    end
    chk("G_no_sys", seen, 0);

    // Table-driven stream under random EXE backpressure, scoreboard checked
    sb_en = 1'b1;
    for (int v = 0; v < 8; v++) begin
      waits = 0;
      while (!In_Ready && waits < 200) begin
        idle_in(); Out_Ready = ($urandom_range(0, 3) != 0);
        cyc(); waits++;
      end
      if (!In_Ready) begin
        total++;
        $display("FAIL tbl_in_ready: got 0 expected 1 for vector %0d", v);
      end
      drive(vecs[v].instr, vecs[v].pc, vecs[v].ser, vecs[v].llsc);
      if (vecs[v].ser) begin
        for (int b = 1; b <= BUBBLES; b++)
          sb_q.push_back('{vecs[v].exp_word, vecs[v].pc, 1'b1,
                           (b == BUBBLES) ? vecs[v].exp_sys : 1'b0});
      end else begin
        sb_q.push_back('{vecs[v].exp_word, vecs[v].pc, 1'b0, 1'b0});
      end
      Out_Ready = ($urandom_range(0, 3) != 0);
      cyc();
      idle_in();
    end
    waits = 0;
    while (sb_q.size() != 0 && waits < 1000) begin
      Out_Ready = ($urandom_range(0, 3) != 0);
      cyc(); waits++;
    end
    chk("sb_drained", sb_q.size(), 0);
    Out_Ready = 1'b1;
    repeat (3) cyc();
    chk("end_idle", {Out_Valid, SYS, WANT_FREEZE, In_Ready}, 4'b0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
